// File: rtl/arb3_pkg.sv
// arb3_pkg: shared types and constants for the three-way round-robin arbiter
package arb3_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int NUM_REQ = 3;
  localparam int CNT_W = 8;
  localparam logic [1:0] LAST_RST = 2'd2;
endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational round-robin pick of one of three requests, searching from the requester after last
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] pick,
  output logic       any
);
  logic [1:0] f0, f1, f2;
  // search order last+1, last+2, last (mod 3); first requesting slot wins
  always_comb begin
    f0 = last == 2'd2 ? 2'd0 : last + 2'd1;
    f1 = f0 == 2'd2 ? 2'd0 : f0 + 2'd1;
    f2 = f1 == 2'd2 ? 2'd0 : f1 + 2'd1;
    pick = req[f0] ? 3'b001 << f0 : req[f1] ? 3'b001 << f1 : req[f2] ? 3'b001 << f2 : 3'b000;
    any = |req;
  end
endmodule

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: round-robin valid/ready arbiter over three operands; ARB3_STATS_EN adds per-requester ack counters
import arb3_pkg::*;
module rr_arbiter3 #(
  parameter int WID = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     req,
  input  logic [WID-1:0] I0,
  input  logic [WID-1:0] I1,
  input  logic [WID-1:0] I2,
  output logic [2:0]     gnt,
  output logic [2:0]     ack,
  output logic [WID-1:0] OUT,
  output logic           out_valid,
  input  logic           out_ready
`ifdef ARB3_STATS_EN
  ,
  output logic [7:0]     grant_cnt0,
  output logic [7:0]     grant_cnt1,
  output logic [7:0]     grant_cnt2
`endif
);
  state_t state;
  logic [1:0] last, gidx, plast;
  logic [2:0] pick;
  logic any, hs, load;
  logic [WID-1:0] sel;
  assign gidx = gnt[1] ? 2'd1 : gnt[2] ? 2'd2 : 2'd0;
  assign hs = out_valid & out_ready;
  assign load = state == IDLE || hs;
  assign plast = state == BUSY ? gidx : last;
  assign sel = pick[0] ? I0 : pick[1] ? I1 : I2;
  assign ack = gnt & {NUM_REQ{hs & ~rst}};
  rr_pick3 u_pick (.req(req), .last(plast), .pick(pick), .any(any));
  // load a new grant when idle or on a handshake; otherwise hold the current transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      OUT <= '0;
      out_valid <= 1'b0;
      last <= LAST_RST;
    end else if (load) begin
      state <= any ? BUSY : IDLE;
      gnt <= pick;
      out_valid <= any;
      if (any) OUT <= sel;
      if (hs) last <= gidx;
    end
  end
`ifdef ARB3_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];
  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
  assign grant_cnt2 = cnt[2];
  // saturating count of completed handshakes per requester
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++)
      if (rst) cnt[k] <= '0;
      else if (ack[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rr_arbiter3.sv
// tb_rr_arbiter3: table vectors plus randomized run against a behavioural round-robin model
module tb_rr_arbiter3;
  logic clk = 0, rst, out_ready, out_valid;
  logic [2:0] req, gnt, ack;
  logic [4:0] i0, i1, i2, out;
`ifdef ARB3_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1, grant_cnt2;
`endif
  always #5 clk = ~clk;
  rr_arbiter3 dut (
    .clk(clk), .rst(rst), .req(req), .I0(i0), .I1(i1), .I2(i2),
    .gnt(gnt), .ack(ack), .OUT(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ARB3_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .grant_cnt2(grant_cnt2)
`endif
  );
  typedef struct {
    logic rs; logic [2:0] rq; logic [4:0] a, b, c; logic rd;
    logic [2:0] eg, ea; logic [4:0] eo; logic ev;
  } vec_t;
  vec_t tab [29];
  int tests = 0, fails = 0;
  bit m_valid;
  int m_win, m_last;
  logic [4:0] m_data;
  int m_cnt [3];
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_win = 0; m_last = 2; m_data = 0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
  endtask
  task automatic model_step();
    int j;
    if (rst) model_reset();
    else if (!m_valid || out_ready) begin
      if (m_valid) begin
        m_last = m_win;
        if (m_cnt[m_win] < 255) m_cnt[m_win]++;
      end
      m_valid = 0;
      for (int k = 1; k <= 3; k++) begin
        j = (m_last + k) % 3;
        if (req[j] && !m_valid) begin
          m_valid = 1; m_win = j;
          m_data = j == 0 ? i0 : j == 1 ? i1 : i2;
        end
      end
    end
  endtask
  task automatic step(input vec_t v, input bit use_tab);
    logic [2:0] eg, ea; logic [4:0] eo; logic ev;
    rst = v.rs; req = v.rq; i0 = v.a; i1 = v.b; i2 = v.c; out_ready = v.rd;
    #1;
    if (use_tab) begin
      eg = v.eg; ea = v.ea; eo = v.eo; ev = v.ev;
    end else begin
      eg = m_valid ? 3'(1 << m_win) : 3'b000;
      ea = (m_valid && out_ready && !rst) ? eg : 3'b000;
      eo = m_data; ev = m_valid;
    end
    chk("gnt", 8'(gnt), 8'(eg));
    chk("ack", 8'(ack), 8'(ea));
    chk("out", 8'(out), 8'(eo));
    chk("out_valid", 8'(out_valid), 8'(ev));
`ifdef ARB3_STATS_EN
    chk("grant_cnt0", grant_cnt0, 8'(m_cnt[0]));
    chk("grant_cnt1", grant_cnt1, 8'(m_cnt[1]));
    chk("grant_cnt2", grant_cnt2, 8'(m_cnt[2]));
`endif
    @(posedge clk);
    model_step();
    #1;
  endtask
  function automatic vec_t mk(logic rs, logic [2:0] rq, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                               logic rd, logic [2:0] eg, logic [4:0] eo, logic ev, logic [2:0] ea);
    vec_t v;
    v.rs = rs; v.rq = rq; v.a = a; v.b = b; v.c = c; v.rd = rd;
    v.eg = eg; v.eo = eo; v.ev = ev; v.ea = ea;
    return v;
  endfunction
  initial begin
    vec_t v;
    tab[0]  = mk(0, 3'b001, 5'h0A, 0, 0, 1, 3'b000, 5'h00, 0, 3'b000);
    tab[1]  = mk(0, 3'b000, 5'h0A, 0, 0, 1, 3'b001, 5'h0A, 1, 3'b001);
    tab[2]  = mk(0, 3'b000, 0, 0, 0, 1, 3'b000, 5'h0A, 0, 3'b000);
    tab[3]  = mk(1, 3'b000, 0, 0, 0, 1, 3'b000, 5'h0A, 0, 3'b000);
    tab[4]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b000, 5'h00, 0, 3'b000);
    tab[5]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b001, 5'h01, 1, 3'b001);
    tab[6]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b010, 5'h02, 1, 3'b010);
    tab[7]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b100, 5'h03, 1, 3'b100);
    tab[8]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b001, 5'h01, 1, 3'b001);
    tab[9]  = mk(0, 3'b111, 1, 2, 3, 1, 3'b010, 5'h02, 1, 3'b010);
    tab[10] = mk(0, 3'b000, 1, 2, 3, 1, 3'b100, 5'h03, 1, 3'b100);
    tab[11] = mk(0, 3'b010, 0, 5'h07, 0, 0, 3'b000, 5'h03, 0, 3'b000);
    tab[12] = mk(0, 3'b010, 0, 5'h08, 0, 0, 3'b010, 5'h07, 1, 3'b000);
    tab[13] = mk(0, 3'b010, 0, 5'h09, 0, 0, 3'b010, 5'h07, 1, 3'b000);
    tab[14] = mk(0, 3'b010, 0, 5'h0A, 0, 0, 3'b010, 5'h07, 1, 3'b000);
    tab[15] = mk(0, 3'b010, 0, 5'h0B, 0, 0, 3'b010, 5'h07, 1, 3'b000);
    tab[16] = mk(0, 3'b000, 0, 5'h0C, 0, 1, 3'b010, 5'h07, 1, 3'b010);
    tab[17] = mk(0, 3'b001, 5'h04, 0, 0, 1, 3'b000, 5'h07, 0, 3'b000);
    tab[18] = mk(0, 3'b011, 5'h04, 5'h06, 0, 1, 3'b001, 5'h04, 1, 3'b001);
    tab[19] = mk(0, 3'b011, 5'h04, 5'h06, 0, 1, 3'b010, 5'h06, 1, 3'b010);
    tab[20] = mk(0, 3'b000, 5'h04, 5'h06, 0, 1, 3'b001, 5'h04, 1, 3'b001);
    tab[21] = mk(0, 3'b111, 1, 2, 3, 0, 3'b000, 5'h04, 0, 3'b000);
    tab[22] = mk(0, 3'b111, 1, 2, 3, 0, 3'b010, 5'h02, 1, 3'b000);
    tab[23] = mk(0, 3'b111, 1, 2, 3, 0, 3'b010, 5'h02, 1, 3'b000);
    tab[24] = mk(1, 3'b111, 1, 2, 3, 1, 3'b010, 5'h02, 1, 3'b000);
    tab[25] = mk(0, 3'b111, 1, 2, 3, 0, 3'b000, 5'h00, 0, 3'b000);
    tab[26] = mk(0, 3'b111, 1, 2, 3, 1, 3'b001, 5'h01, 1, 3'b001);
    tab[27] = mk(0, 3'b000, 1, 2, 3, 1, 3'b010, 5'h02, 1, 3'b010);
    tab[28] = mk(0, 3'b000, 0, 0, 0, 1, 3'b000, 5'h02, 0, 3'b000);
    rst = 1; req = 0; i0 = 0; i1 = 0; i2 = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    for (int t = 0; t < 29; t++) step(tab[t], 1);
    for (int t = 0; t < 500; t++) begin
      v = mk($urandom_range(0, 49) == 0, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom_range(0, 3) != 0, 0, 0, 0, 0);
      step(v, 0);
    end
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    for (int t = 0; t < 302; t++) step(mk(0, 3'b100, 0, 0, 5'($urandom), 1, 0, 0, 0, 0), 0);
`ifdef ARB3_STATS_EN
    chk("sat_cnt2", grant_cnt2, 8'd255);
    chk("sat_cnt0", grant_cnt0, 8'd0);
    chk("sat_cnt1", grant_cnt1, 8'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
